// File: rtl/imem_sync_loadable.sv
// Loadable big-endian instruction memory with 1-cycle registered fetch.
// Optional macro IMEM_PARITY_EN adds per-word even parity storage and checks.
module imem_sync_loadable #(
  parameter int          DEPTH_BYTES = 256,
  parameter int          ADDR_W      = 32,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              fetch_fault,
  output logic              fetch_busy,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [CNT_W-1:0]  ld_count,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  output logic              ld_done,
  output logic              ld_err
`ifdef IMEM_PARITY_EN
  ,
  output logic              parity_err,
  input  logic              parity_inject
`endif
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH_BYTES - 4);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t state, state_nx;

  logic [31:0]       mem [WORDS];
  logic [ADDR_W-1:0] ptr;
  logic              ptr_ovf;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W:0]   ptr_inc;

  logic fetch_ok, fetch_bad;
  logic start_ok, ld_acc, last_word;
  logic wr_ok, wr_en;
  logic [IDX_W-1:0] f_idx, w_idx;

  assign fetch_busy = (state == LOAD);
  assign ld_ready   = (state == LOAD);

  assign fetch_ok  = fetch_en && (state == IDLE);
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) ||
                     (fetch_addr > LAST);
  assign f_idx     = fetch_addr[IDX_W+1:2];

  assign start_ok  = ld_start && (state == IDLE);
  assign ld_acc    = ld_valid && (state == LOAD);
  assign last_word = ld_acc && (remaining == CNT_W'(1));

  // A carry out of the pointer means the load ran past the address space.
  assign ptr_inc = {1'b0, ptr} + (ADDR_W+1)'(4);
  assign wr_ok   = !ptr_ovf && (ptr <= LAST);
  assign wr_en   = ld_acc && wr_ok;
  assign w_idx   = ptr[IDX_W+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (ld_start && (ld_count != '0)) state_nx = LOAD;
      LOAD: if (last_word) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[w_idx] <= ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      ld_done     <= 1'b0;
      ld_err      <= 1'b0;
      ptr         <= '0;
      ptr_ovf     <= 1'b0;
      remaining   <= '0;
    end else begin
      instr_valid <= fetch_ok;
      if (fetch_ok) begin
        fetch_fault <= fetch_bad;
        instr       <= fetch_bad ? NOP_WORD : mem[f_idx];
      end
      ld_done <= (start_ok && (ld_count == '0)) || last_word;
      if (start_ok) begin
        ptr       <= {ld_base[ADDR_W-1:2], 2'b00};
        ptr_ovf   <= 1'b0;
        remaining <= ld_count;
        ld_err    <= (ld_base[1:0] != 2'b00);
      end else if (ld_acc) begin
        ptr       <= ptr_inc[ADDR_W-1:0];
        ptr_ovf   <= ptr_ovf | ptr_inc[ADDR_W];
        remaining <= remaining - CNT_W'(1);
        if (!wr_ok) ld_err <= 1'b1;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic mem_par [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem_par[w_idx] <= (^ld_data) ^ parity_inject;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (fetch_ok) begin
      parity_err <= !fetch_bad &&
                    ((^mem[f_idx]) != mem_par[f_idx]);
    end
  end
`endif

endmodule
